// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, Status/Cause layouts
// and the software write masks.
package cp0_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  typedef enum logic [4:0] {
    INT  = 5'd0,
    ADEL = 5'd4,
    ADES = 5'd5,
    SYS  = 5'd8,
    BP   = 5'd9,
    RI   = 5'd10,
    OV   = 5'd12
  } exccode_t;

  typedef struct packed {
    logic [8:0] rsvd_hi;
    logic       bev;
    logic [5:0] rsvd_mid;
    logic [7:0] im;
    logic [5:0] rsvd_lo;
    logic       exl;
    logic       ie;
  } cp0_status_t;

  typedef struct packed {
    logic        bd;
    logic        ti;
    logic [13:0] rsvd_hi;
    logic [7:0]  ip;
    logic        rsvd_mid;
    logic [4:0]  exc_code;
    logic [1:0]  rsvd_lo;
  } cp0_cause_t;

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

  function automatic logic [31:0] apply_wmask(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [31:0] mask);
    return (cur & ~mask) | (wdata & mask);
  endfunction

  // Only address errors carry a meaningful faulting address.
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == ADEL) || (code == ADES);
  endfunction

endpackage

// File: rtl/cp0_regs_timer.sv
// Count/Compare timer: Count advances every second clock; TI (only when
// CP0_TIMER_INT_EN is defined) latches on Count==Compare until Compare is written.
module cp0_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wr_data,
  input  logic [31:0] compare_next,
  output logic [31:0] count,
  output logic        ti
);

  logic [31:0] count_reg, count_next;
  logic        toggle_reg, toggle_next;

  always_comb begin
    count_next  = count_reg;
    toggle_next = ~toggle_reg;
    if (count_we) begin
      count_next  = wr_data;
      toggle_next = 1'b0;
    end else if (toggle_reg) begin
      count_next = count_reg + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg  <= '0;
      toggle_reg <= 1'b0;
    end else begin
      count_reg  <= count_next;
      toggle_reg <= toggle_next;
    end
  end

  assign count = count_reg;

`ifdef CP0_TIMER_INT_EN
  logic ti_reg, ti_next;

  // A Compare write acknowledges the interrupt and beats a coincident match.
  always_comb begin
    ti_next = ti_reg;
    if (count_next == compare_next) ti_next = 1'b1;
    if (compare_we)                 ti_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) ti_reg <= 1'b0;
    else       ti_reg <= ti_next;
  end

  assign ti = ti_reg;
`else
  logic unused_timer_inputs;
  assign unused_timer_inputs = ^{compare_we, compare_next};
  assign ti = 1'b0;
`endif

endmodule

// File: rtl/cp0_regs.sv
// CP0 register file: MTC0/MFC0, exception and ERET commit, fetch redirect and
// interrupt-pending. Timer interrupt is enabled by defining CP0_TIMER_INT_EN.
module cp0_regs
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_valid,
  input  logic [4:0]  wr_id,
  input  logic [31:0] wr_data,
  input  logic [4:0]  rd_id,
  output logic [31:0] rd_data,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic [31:0] exc_badvaddr,
  input  logic        eret_valid,
  input  logic [5:0]  ext_int,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        int_pending
);

  cp0_status_t status_reg, status_wr, status_next;
  cp0_cause_t  cause_reg, cause_view, cause_wr, cause_next;
  logic [31:0] epc_reg, epc_wr, epc_next;
  logic [31:0] badvaddr_reg, badvaddr_next;
  logic [31:0] compare_reg, compare_next;
  logic [31:0] count, count_wr;
  logic        ti;
  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;

  assign wr_count   = wr_valid && (wr_id == CP0_COUNT);
  assign wr_compare = wr_valid && (wr_id == CP0_COMPARE);
  assign wr_status  = wr_valid && (wr_id == CP0_STATUS);
  assign wr_cause   = wr_valid && (wr_id == CP0_CAUSE);
  assign wr_epc     = wr_valid && (wr_id == CP0_EPC);

  cp0_timer u_timer (
    .clk          (clk),
    .reset        (reset),
    .count_we     (wr_count),
    .compare_we   (wr_compare),
    .wr_data      (wr_data),
    .compare_next (compare_next),
    .count        (count),
    .ti           (ti)
  );

  // Architectural view of each register with this cycle's MTC0 folded in.
  always_comb begin
    status_wr = status_reg;
    if (wr_status) status_wr = cp0_status_t'(apply_wmask(status_reg, wr_data, STATUS_WMASK));
    status_wr.bev = 1'b1;

    cause_view       = cause_reg;
    cause_view.ti    = ti;
    cause_view.ip[7] = cause_reg.ip[7] | ti;

    cause_wr = cause_view;
    if (wr_cause) cause_wr = cp0_cause_t'(apply_wmask(cause_view, wr_data, CAUSE_WMASK));

    epc_wr       = wr_epc     ? wr_data : epc_reg;
    compare_next = wr_compare ? wr_data : compare_reg;
    count_wr     = wr_count   ? wr_data : count;
  end

  // Exception/ERET commit on top of the MTC0 result; the older writeback loses.
  always_comb begin
    status_next   = status_wr;
    cause_next    = cause_reg;
    epc_next      = epc_wr;
    badvaddr_next = badvaddr_reg;

    if (wr_cause) cause_next = cp0_cause_t'(apply_wmask(cause_reg, wr_data, CAUSE_WMASK));
    cause_next.ip[7:2] = ext_int;
    cause_next.ti      = 1'b0;

    if (exc_valid) begin
      if (!status_wr.exl) begin
        epc_next      = exc_bd ? (exc_pc - 32'd4) : exc_pc;
        cause_next.bd = exc_bd;
      end
      cause_next.exc_code = exc_code;
      status_next.exl     = 1'b1;
      if (is_addr_exc(exc_code)) badvaddr_next = exc_badvaddr;
    end else if (eret_valid) begin
      status_next.exl = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      status_reg   <= cp0_status_t'(STATUS_RESET);
      cause_reg    <= '0;
      epc_reg      <= '0;
      badvaddr_reg <= '0;
      compare_reg  <= '0;
    end else begin
      status_reg   <= status_next;
      cause_reg    <= cause_next;
      epc_reg      <= epc_next;
      badvaddr_reg <= badvaddr_next;
      compare_reg  <= compare_next;
    end
  end

  always_comb begin
    case (rd_id)
      CP0_BADVADDR: rd_data = badvaddr_reg;
      CP0_COUNT:    rd_data = count_wr;
      CP0_COMPARE:  rd_data = compare_next;
      CP0_STATUS:   rd_data = status_wr;
      CP0_CAUSE:    rd_data = cause_wr;
      CP0_EPC:      rd_data = epc_wr;
      default:      rd_data = '0;
    endcase
  end

  assign redirect    = exc_valid | eret_valid;
  assign redirect_pc = exc_valid ? EXC_VECTOR : epc_wr;

  assign int_pending = status_reg.ie & ~status_reg.exl & (|(status_reg.im & cause_view.ip));

endmodule
